// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and queues it in a small FIFO.
// Optional statistics counters are enabled by defining INST_ENCODER_STAT_EN.
`ifndef INST_ENCODER_DEFS
`define INST_ENCODER_DEFS
`define INST_R        7'b0110011
`define INST_I        7'b0010011
`define INST_B        7'b1100011
`define INST_L        7'b0000011
`define INST_S        7'b0100011
`define INST_JAL      7'b1101111
`define INST_JALR     7'b1100111
`define INST_LUI      7'b0110111
`define INST_AUIPC    7'b0010111
`define ALU_INST_BUS  [3:0]
`define ALU_ADD       4'd0
`define ALU_SUB       4'd1
`define ALU_LL        4'd2
`define ALU_CMP_LESS  4'd3
`define ALU_CMP_LESSU 4'd4
`define ALU_XOR       4'd5
`define ALU_RL        4'd6
`define ALU_ARL       4'd7
`define ALU_OR        4'd8
`define ALU_AND       4'd9
`define ALU_CMP_EQ    4'd10
`define ALU_CMP_NEQ   4'd11
`define ALU_CMP_MORE_EQ  4'd12
`define ALU_CMP_MORE_EQU 4'd13
`define DATA_TYPE_BUS [2:0]
`define DATATYPE_BYTE  3'd0
`define DATATYPE_HALF  3'd1
`define DATATYPE_WORD  3'd2
`define DATATYPE_UBYTE 3'd3
`define DATATYPE_UHALF 3'd4
`endif

module inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [6:0]          opcode_i,
  input  logic `ALU_INST_BUS  alu_inst_i,
  input  logic `DATA_TYPE_BUS data_type_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [4:0]          rd_i,
  input  logic [31:0]         imm_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_inst_o,
  output logic                out_err_o,
  output logic [CNT_W-1:0]    cnt_ok_o,
  output logic [CNT_W-1:0]    cnt_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

  // Immediate range checks: a signed value fits when all bits above the field agree.
  logic fit12, fit_sh, fit_b, fit_j, fit_u;
  assign fit12  = &imm_i[31:11] | ~|imm_i[31:11];
  assign fit_sh = ~|imm_i[31:5];
  assign fit_b  = (&imm_i[31:12] | ~|imm_i[31:12]) & ~imm_i[0];
  assign fit_j  = (&imm_i[31:20] | ~|imm_i[31:20]) & ~imm_i[0];
  assign fit_u  = &imm_i[31:19] | ~|imm_i[31:19];

  logic [2:0] alu_f3, br_f3, ld_f3, st_f3;
  logic       alu_ok, alu_alt, br_ok, ld_ok, st_ok;

  always_comb begin
    alu_f3 = 3'b000; alu_ok = 1'b1; alu_alt = 1'b0;
    case (alu_inst_i)
      `ALU_ADD:       alu_f3 = 3'b000;
      `ALU_SUB:       begin alu_f3 = 3'b000; alu_alt = 1'b1; end
      `ALU_LL:        alu_f3 = 3'b001;
      `ALU_CMP_LESS:  alu_f3 = 3'b010;
      `ALU_CMP_LESSU: alu_f3 = 3'b011;
      `ALU_XOR:       alu_f3 = 3'b100;
      `ALU_RL:        alu_f3 = 3'b101;
      `ALU_ARL:       begin alu_f3 = 3'b101; alu_alt = 1'b1; end
      `ALU_OR:        alu_f3 = 3'b110;
      `ALU_AND:       alu_f3 = 3'b111;
      default:        alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_f3 = 3'b000; br_ok = 1'b1;
    case (alu_inst_i)
      `ALU_CMP_EQ:       br_f3 = 3'b000;
      `ALU_CMP_NEQ:      br_f3 = 3'b001;
      `ALU_CMP_LESS:     br_f3 = 3'b100;
      `ALU_CMP_MORE_EQ:  br_f3 = 3'b101;
      `ALU_CMP_LESSU:    br_f3 = 3'b110;
      `ALU_CMP_MORE_EQU: br_f3 = 3'b111;
      default:           br_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_f3 = 3'b000; ld_ok = 1'b1;
    case (data_type_i)
      `DATATYPE_BYTE:  ld_f3 = 3'b000;
      `DATATYPE_HALF:  ld_f3 = 3'b001;
      `DATATYPE_WORD:  ld_f3 = 3'b010;
      `DATATYPE_UBYTE: ld_f3 = 3'b100;
      `DATATYPE_UHALF: ld_f3 = 3'b101;
      default:         ld_ok = 1'b0;
    endcase
    // Stores share the load width codes but have no unsigned variants.
    st_f3 = ld_f3;
    st_ok = ld_ok & ~ld_f3[2];
  end

  logic [31:0] raw, enc_inst;
  logic        bad, enc_err, is_shift;

  assign is_shift = (alu_inst_i == `ALU_LL) | (alu_inst_i == `ALU_RL) | (alu_inst_i == `ALU_ARL);

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (opcode_i)
      `INST_R: begin
        raw = {1'b0, alu_alt, 5'b0, rs2_i, rs1_i, alu_f3, rd_i, opcode_i};
        bad = ~alu_ok;
      end
      `INST_I: begin
        if (is_shift) begin
          raw = {1'b0, alu_alt, 5'b0, imm_i[4:0], rs1_i, alu_f3, rd_i, opcode_i};
          bad = ~fit_sh;
        end else begin
          raw = {imm_i[11:0], rs1_i, alu_f3, rd_i, opcode_i};
          bad = ~alu_ok | (alu_inst_i == `ALU_SUB) | ~fit12;
        end
      end
      `INST_B: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, br_f3, imm_i[4:1], imm_i[11], opcode_i};
        bad = ~br_ok | ~fit_b;
      end
      `INST_L: begin
        raw = {imm_i[11:0], rs1_i, ld_f3, rd_i, opcode_i};
        bad = ~ld_ok | ~fit12;
      end
      `INST_S: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, st_f3, imm_i[4:0], opcode_i};
        bad = ~st_ok | ~fit12;
      end
      `INST_JAL: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad = ~fit_j;
      end
      `INST_JALR: begin
        raw = {imm_i[11:0], rs1_i, 3'b000, rd_i, opcode_i};
        bad = ~fit12;
      end
      `INST_LUI, `INST_AUIPC: begin
        raw = {imm_i[19:0], rd_i, opcode_i};
        bad = ~fit_u;
      end
      default: bad = 1'b1;
    endcase
  end

  assign enc_err  = bad;
  assign enc_inst = bad ? NOP : raw;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;

  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_inst_o  = out_valid_o ? mem[rd_ptr].inst : '0;
  assign out_err_o   = out_valid_o & mem[rd_ptr].err;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Storage is unreset; stale slots are never visible because the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: enc_inst, err: enc_err};
  end

`ifdef INST_ENCODER_STAT_EN
  logic [CNT_W-1:0] cnt_ok, cnt_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (push && !flush_i) begin
      if (enc_err) begin
        if (~&cnt_err) cnt_err <= cnt_err + CNT_W'(1);
      end else begin
        if (~&cnt_ok) cnt_ok <= cnt_ok + CNT_W'(1);
      end
    end
  end
  assign cnt_ok_o  = cnt_ok;
  assign cnt_err_o = cnt_err;
`else
  assign cnt_ok_o  = '0;
  assign cnt_err_o = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed test-plan steps followed by randomized traffic against a queue model.
`ifndef INST_ENCODER_DEFS
`define INST_ENCODER_DEFS
`define INST_R        7'b0110011
`define INST_I        7'b0010011
`define INST_B        7'b1100011
`define INST_L        7'b0000011
`define INST_S        7'b0100011
`define INST_JAL      7'b1101111
`define INST_JALR     7'b1100111
`define INST_LUI      7'b0110111
`define INST_AUIPC    7'b0010111
`define ALU_INST_BUS  [3:0]
`define ALU_ADD       4'd0
`define ALU_SUB       4'd1
`define ALU_LL        4'd2
`define ALU_CMP_LESS  4'd3
`define ALU_CMP_LESSU 4'd4
`define ALU_XOR       4'd5
`define ALU_RL        4'd6
`define ALU_ARL       4'd7
`define ALU_OR        4'd8
`define ALU_AND       4'd9
`define ALU_CMP_EQ    4'd10
`define ALU_CMP_NEQ   4'd11
`define ALU_CMP_MORE_EQ  4'd12
`define ALU_CMP_MORE_EQU 4'd13
`define DATA_TYPE_BUS [2:0]
`define DATATYPE_BYTE  3'd0
`define DATATYPE_HALF  3'd1
`define DATATYPE_WORD  3'd2
`define DATATYPE_UBYTE 3'd3
`define DATATYPE_UHALF 3'd4
`endif

module tb_inst_encoder;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [6:0]  opcode = '0;
  logic [3:0]  alu = '0;
  logic [2:0]  dt = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [CNT_W-1:0] cnt_ok, cnt_err;

  int n_chk = 0, n_fail = 0;

  typedef struct { logic [31:0] inst; bit err; } ent_t;
  ent_t q[$];
  int   m_ok = 0, m_err = 0;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .alu_inst_i(alu), .data_type_i(dt), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_inst_o(out_inst), .out_err_o(out_err), .cnt_ok_o(cnt_ok), .cnt_err_o(cnt_err)
  );

  always #5 clk = ~clk;

  function automatic int stat(input int v);
`ifdef INST_ENCODER_STAT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_f(input logic [6:0] o, input logic [3:0] a, input logic [2:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                       input logic [31:0] im);
    opcode = o; alu = a; dt = d; rs1 = r1; rs2 = r2; rd = rdd; imm = im;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Push one entry with the consumer ready, check the head, then let it drain.
  task automatic push_chk(input string tag, input logic [31:0] e_inst, input logic e_err);
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_inst"}, out_inst, e_inst);
    chk({tag, "_err"}, out_err, e_err);
    tick;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  // Reference encoder built from the field tables and plain shift arithmetic.
  function automatic int rr_f3(input logic [3:0] a);
    case (a)
      `ALU_ADD, `ALU_SUB: return 0;
      `ALU_LL:            return 1;
      `ALU_CMP_LESS:      return 2;
      `ALU_CMP_LESSU:     return 3;
      `ALU_XOR:           return 4;
      `ALU_RL, `ALU_ARL:  return 5;
      `ALU_OR:            return 6;
      `ALU_AND:           return 7;
      default:            return -1;
    endcase
  endfunction

  function automatic int br_f3(input logic [3:0] a);
    case (a)
      `ALU_CMP_EQ:       return 0;
      `ALU_CMP_NEQ:      return 1;
      `ALU_CMP_LESS:     return 4;
      `ALU_CMP_MORE_EQ:  return 5;
      `ALU_CMP_LESSU:    return 6;
      `ALU_CMP_MORE_EQU: return 7;
      default:           return -1;
    endcase
  endfunction

  function automatic int mem_f3(input logic [2:0] d, input bit is_store);
    case (d)
      `DATATYPE_BYTE:  return 0;
      `DATATYPE_HALF:  return 1;
      `DATATYPE_WORD:  return 2;
      `DATATYPE_UBYTE: return is_store ? -1 : 4;
      `DATATYPE_UHALF: return is_store ? -1 : 5;
      default:         return -1;
    endcase
  endfunction

  function automatic ent_t ref_enc(input logic [6:0] o, input logic [3:0] a, input logic [2:0] d,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                                   input logic [31:0] im);
    ent_t e;
    int s, f;
    bit ok;
    logic [31:0] u, w, x1, x2, xd, op;
    s = int'($signed(im)); u = im; x1 = 32'(r1); x2 = 32'(r2); xd = 32'(rdd); op = 32'(o);
    ok = 1'b1; w = '0;
    if (o == `INST_R) begin
      f = rr_f3(a); ok = (f >= 0);
      w = ((a == `ALU_SUB || a == `ALU_ARL) ? 32'h20 : 32'h0) << 25 | x2 << 20 | x1 << 15
          | 32'(f) << 12 | xd << 7 | op;
    end else if (o == `INST_I) begin
      f = rr_f3(a);
      if (a == `ALU_LL || a == `ALU_RL || a == `ALU_ARL) begin
        ok = (s >= 0 && s <= 31);
        w = ((a == `ALU_ARL) ? 32'h20 : 32'h0) << 25 | (u & 32'h1F) << 20 | x1 << 15
            | 32'(f) << 12 | xd << 7 | op;
      end else begin
        ok = (f >= 0) && (a != `ALU_SUB) && (s >= -2048 && s <= 2047);
        w = (u & 32'hFFF) << 20 | x1 << 15 | 32'(f) << 12 | xd << 7 | op;
      end
    end else if (o == `INST_B) begin
      f = br_f3(a);
      ok = (f >= 0) && (s >= -4096 && s <= 4094) && (s % 2 == 0);
      w = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3F) << 25 | x2 << 20 | x1 << 15
          | 32'(f) << 12 | ((u >> 1) & 32'hF) << 8 | ((u >> 11) & 1) << 7 | op;
    end else if (o == `INST_L) begin
      f = mem_f3(d, 1'b0);
      ok = (f >= 0) && (s >= -2048 && s <= 2047);
      w = (u & 32'hFFF) << 20 | x1 << 15 | 32'(f) << 12 | xd << 7 | op;
    end else if (o == `INST_S) begin
      f = mem_f3(d, 1'b1);
      ok = (f >= 0) && (s >= -2048 && s <= 2047);
      w = ((u >> 5) & 32'h7F) << 25 | x2 << 20 | x1 << 15 | 32'(f) << 12 | (u & 32'h1F) << 7 | op;
    end else if (o == `INST_JAL) begin
      ok = (s >= -(1 << 20) && s <= (1 << 20) - 2) && (s % 2 == 0);
      w = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3FF) << 21 | ((u >> 11) & 1) << 20
          | ((u >> 12) & 32'hFF) << 12 | xd << 7 | op;
    end else if (o == `INST_JALR) begin
      ok = (s >= -2048 && s <= 2047);
      w = (u & 32'hFFF) << 20 | x1 << 15 | xd << 7 | op;
    end else if (o == `INST_LUI || o == `INST_AUIPC) begin
      ok = (s >= -(1 << 19) && s <= (1 << 19) - 1);
      w = (u & 32'hFFFFF) << 12 | xd << 7 | op;
    end else begin
      ok = 1'b0;
    end
    e.inst = ok ? w : 32'h0000_0013;
    e.err  = !ok;
    return e;
  endfunction

  logic [6:0] ops [9] = '{`INST_R, `INST_I, `INST_B, `INST_L, `INST_S,
                          `INST_JAL, `INST_JALR, `INST_LUI, `INST_AUIPC};
  int bnd [22] = '{0, 31, 32, -1, 2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                   1048574, 1048575, 1048576, -1048576, -1048578, 524287, 524288,
                   -524288, -524289, 6};

  initial begin
    @(negedge clk);
    do_reset;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt_ok", cnt_ok, 0);
    chk("rst_cnt_err", cnt_err, 0);

    set_f(`INST_I, `ALU_ADD, `DATATYPE_BYTE, 0, 0, 1, 32'd5);
    push_chk("addi", 32'h0050_0093, 1'b0);
    set_f(`INST_R, `ALU_SUB, `DATATYPE_BYTE, 1, 2, 3, 32'd0);
    push_chk("sub", 32'h4020_81B3, 1'b0);
    set_f(`INST_B, `ALU_CMP_EQ, `DATATYPE_BYTE, 1, 2, 0, 32'hFFFF_FFFC);
    push_chk("beq", 32'hFE20_8EE3, 1'b0);
    set_f(`INST_S, `ALU_ADD, `DATATYPE_WORD, 2, 5, 0, 32'd4096);
    push_chk("sw_range", 32'h0000_0013, 1'b1);
    chk("stat_ok_3", cnt_ok, stat(3));
    chk("stat_err_1", cnt_err, stat(1));
    set_f(`INST_S, `ALU_ADD, `DATATYPE_WORD, 2, 5, 0, 32'd8);
    push_chk("sw", 32'h0051_2423, 1'b0);
    do_reset;
    chk("stat_rst_ok", cnt_ok, 0);
    chk("stat_rst_err", cnt_err, 0);

    // Backpressure: third push waits until the consumer drains.
    out_ready = 1'b0; in_valid = 1'b1;
    set_f(`INST_I, `ALU_ADD, `DATATYPE_BYTE, 0, 0, 1, 32'd5);
    tick;
    chk("bp_ready_1", in_ready, 1);
    set_f(`INST_R, `ALU_SUB, `DATATYPE_BYTE, 1, 2, 3, 32'd0);
    tick;
    chk("bp_full", in_ready, 0);
    chk("bp_head_a", out_inst, 32'h0050_0093);
    set_f(`INST_B, `ALU_CMP_EQ, `DATATYPE_BYTE, 1, 2, 0, 32'hFFFF_FFFC);
    tick;
    chk("bp_held", in_ready, 0);
    chk("bp_head_a2", out_inst, 32'h0050_0093);
    out_ready = 1'b1;
    tick;
    chk("bp_head_b", out_inst, 32'h4020_81B3);
    chk("bp_ready_2", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_head_c", out_inst, 32'hFE20_8EE3);
    tick;
    chk("bp_empty", out_valid, 0);

    // Flush beats a concurrent push, both when full and when partially filled.
    out_ready = 1'b0; in_valid = 1'b1;
    tick; tick;
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    in_valid = 1'b1;
    tick;
    set_f(`INST_I, `ALU_ADD, `DATATYPE_BYTE, 0, 0, 1, 32'd5);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_part_valid", out_valid, 0);
    tick;
    chk("fl_lost", out_valid, 0);

    // Saturation of the ok counter, and flush leaves counters alone.
    do_reset;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < CMAX + 3; i++) tick;
    in_valid = 1'b0;
    chk("sat_ok", cnt_ok, stat(CMAX));
    chk("sat_err", cnt_err, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_keeps_cnt", cnt_ok, stat(CMAX));

    // Randomized traffic against the queue model.
    do_reset;
    q.delete(); m_ok = 0; m_err = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ent_t e;
      bit rdy;
      int v;
      chk("rnd_in_ready", in_ready, (q.size() < DEPTH));
      chk("rnd_out_valid", out_valid, (q.size() != 0));
      chk("rnd_out_inst", out_inst, (q.size() != 0) ? q[0].inst : 32'h0);
      chk("rnd_out_err", out_err, (q.size() != 0) ? q[0].err : 1'b0);
      chk("rnd_cnt_ok", cnt_ok, stat(m_ok));
      chk("rnd_cnt_err", cnt_err, stat(m_err));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        q.delete(); m_ok = 0; m_err = 0;
      end else begin
        rst = 1'b0;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 39) == 0);
        opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        alu = 4'($urandom); dt = 3'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: begin v = int'($urandom_range(0, 80)) - 40; imm = 32'(v); end
          2: imm = 32'(bnd[$urandom_range(0, 21)]);
          default: begin v = int'($urandom_range(0, 20000)) - 10000; imm = 32'(v); end
        endcase
        e = ref_enc(opcode, alu, dt, rs1, rs2, rd, imm);
        rdy = (q.size() < DEPTH);
        if (flush) q.delete();
        else begin
          if (out_ready && q.size() != 0) void'(q.pop_front());
          if (in_valid && rdy) begin
            q.push_back(e);
            if (e.err) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
            else       m_ok  = (m_ok  < CMAX) ? m_ok  + 1 : CMAX;
          end
        end
      end
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- RV32I instruction encoder: the inverse of the decode stage.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit instruction word.
- Flags field combinations that cannot be encoded.
- Buffers results in a small FIFO toward a valid/ready consumer; used by debug-program injection and self-test stimulus generators feeding the fetch path.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush_i  input  1  discard all buffered entries
in_valid_i  input  1  fields valid
in_ready_o  output  1  encoder can accept
opcode_i  input  7  instruction class, `inst_r/`inst_i/`inst_b/`inst_l/`inst_s/`inst_jal/`inst_jalr/`inst_lui/`inst_auipc
alu_inst_i  input  `alu_inst_bus  ALU op, define.v encoding
data_type_i  input  `data_type_bus  load/store width, define.v encoding
rs1_i  input  5  source reg 1
rs2_i  input  5  source reg 2
rd_i  input  5  destination reg
imm_i  input  32  sign-extended immediate; byte offset for B/J; upper 20 bits value for LUI/AUIPC
out_valid_o  output  1  FIFO head valid
out_ready_i  input  1  consumer accepts head
out_inst_o  output  32  encoded instruction
out_err_o  output  1  head entry was unencodable
cnt_ok_o  output  CNT_W  encoded-ok count (see Optional Feature)
cnt_err_o  output  CNT_W  error count (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at clk edge): FIFO empty; out_valid_o=0, out_inst_o=0, out_err_o=0, counters=0, in_ready_o=1.
- Push occurs when in_valid_i & in_ready_o. Pop occurs when out_valid_o & out_ready_i.
- in_ready_o = !full, registered-count based. No push when full, even if a pop happens in the same cycle.
- Latency: an entry pushed in cycle N appears at the head in N+1 if the FIFO was empty.
- Push and pop in the same cycle: occupancy unchanged; order preserved.
- Pointers wrap modulo DEPTH.
- flush_i: clears all entries next edge. Has priority over push and pop in that cycle; the pushed entry is dropped and counters do not increment for it.
- Encoding is combinational on inputs; the result is registered into the FIFO.
- func3/func7 mapping:
  - R: add 000/00, sub 000/20, ll 001/00, cmp_less 010, cmp_lessu 011, xor 100, rl 101/00, arl 101/20, or 110, and 111.
  - I: same func3, no func7. Shifts: inst[31:25]=00 (ll, rl) or 20 (arl); inst[24:20]=imm[4:0]. sub is an error.
  - B: cmp_eq 000, cmp_neq 001, cmp_less 100, cmp_more_eq 101, cmp_lessu 110, cmp_more_equ 111.
  - L: byte 000, half 001, word 010, ubyte 100, uhalf 101.
  - S: byte 000, half 001, word 010.
  - JALR: 000.
- Immediate range checks, all signed:
  - I/L/S/JALR: -2048..2047.
  - I shifts: 0..31.
  - B: -4096..4094 and even.
  - JAL: -2^20..2^20-2 and even.
  - LUI/AUIPC: -2^19..2^19-1; inst[31:12]=imm[19:0].
- Bit placement is the standard RV32I I/S/B/U/J layout.
- Error conditions: unknown opcode, op/type not listed for the class, or immediate out of range. The entry is stored with out_err_o=1 and out_inst_o=32'h00000013 (NOP).
- Unused register fields are encoded as given, e.g. rs2 for I-type is ignored and not checked.
- Reset mid-stream drops all entries.

Optional Feature:
- Macro: INST_ENCODER_STAT_EN.
- Defined: cnt_ok_o/cnt_err_o increment on each accepted push (ok vs err). They saturate at all-ones, reset to 0, and are unaffected by flush_i.
- Undefined: both ports are driven constant 0 and no counter logic is present.

Test Plan:
- addi x1,x0,5 (`inst_i, `alu_add, rd=1, imm=5), out_ready_i=1 -> out_valid_o next cycle, out_inst_o=0x00500093, out_err_o=0.
- sub x3,x1,x2 (`inst_r, `alu_sub) -> 0x402081B3. beq x1,x2,-4 (`inst_b, `alu_cmp_eq, imm=32'hFFFFFFFC) -> 0xFE208EE3.
- sw x5,8(x2) (`inst_s, `datatype_word, rs1=2, rs2=5, imm=8) -> 0x00512423. Same with imm=4096 -> out_err_o=1, out_inst_o=0x00000013.
- out_ready_i=0, push 3 entries with DEPTH=2 -> in_ready_o=0 after 2 pushes; the third is held until out_ready_i=1; all drained in order.
- Full FIFO, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, pushed entry lost.
- INST_ENCODER_STAT_EN defined: 3 good and 1 bad push -> cnt_ok_o=3, cnt_err_o=1. Reset -> both 0.
